// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: selectable step, parallel load with range check,
// programmable modulus. Define UPDOWN_COUNTER_SATURATE_EN to saturate instead of wrap.
module updown_counter_param #(
  parameter int unsigned     WIDTH       = 16,
  parameter int unsigned     STEP_WIDTH  = 4,
  parameter longint unsigned MAX_VALUE   = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned RESET_VALUE = 64'd0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            control,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [WIDTH-1:0]      load_value,
  output logic [WIDTH-1:0]      out,
  output logic                  wrap,
  output logic                  load_err,
  output logic                  at_max,
  output logic                  at_zero
);

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_UP    = 2'b01,
    OP_LOAD  = 2'b10,
    OP_DOWN  = 2'b11
  } op_e;

  // Parameter sanity checks, reported at elaboration.
  if (WIDTH < 2 || WIDTH > 63) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be in 2..63");
  end
  if (STEP_WIDTH < 1 || STEP_WIDTH > WIDTH) begin : g_bad_step_width
    $error("updown_counter_param: STEP_WIDTH must be in 1..WIDTH");
  end
  if (MAX_VALUE > ((64'd1 << WIDTH) - 64'd1) ||
      MAX_VALUE < ((64'd1 << STEP_WIDTH) - 64'd1)) begin : g_bad_max
    $error("updown_counter_param: MAX_VALUE out of range");
  end
  if (RESET_VALUE > MAX_VALUE) begin : g_bad_reset
    $error("updown_counter_param: RESET_VALUE exceeds MAX_VALUE");
  end

  localparam logic [WIDTH:0]   MAX_W  = MAX_VALUE[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_LO = MAX_W[WIDTH-1:0];
  // Modulus truncated to WIDTH bits; zero when the counter spans the full range.
  localparam logic [WIDTH-1:0] MOD_LO = MAX_LO + {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] RST_LO = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic [WIDTH-1:0] step_w;
  logic [WIDTH:0]   sum_w;
  op_e              op;

  if (STEP_WIDTH < WIDTH) begin : g_step_ext
    assign step_w = {{(WIDTH-STEP_WIDTH){1'b0}}, step};
  end else begin : g_step_full
    assign step_w = step;
  end

  assign op    = op_e'(control);
  assign sum_w = {1'b0, out_q} + {1'b0, step_w};

  // Wrapped results are formed modulo 2**WIDTH; the true value is always in 0..MAX_VALUE.
  always_comb begin
    out_d      = out_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (enable) begin
      case (op)
        OP_CLEAR: out_d = '0;
        OP_UP: begin
          if (sum_w <= MAX_W) begin
            out_d = sum_w[WIDTH-1:0];
          end else begin
            wrap_d = 1'b1;
`ifdef UPDOWN_COUNTER_SATURATE_EN
            out_d  = MAX_LO;
`else
            out_d  = sum_w[WIDTH-1:0] - MOD_LO;
`endif
          end
        end
        OP_DOWN: begin
          if (step_w <= out_q) begin
            out_d = out_q - step_w;
          end else begin
            wrap_d = 1'b1;
`ifdef UPDOWN_COUNTER_SATURATE_EN
            out_d  = '0;
`else
            out_d  = out_q - step_w + MOD_LO;
`endif
          end
        end
        OP_LOAD: begin
          if (load_value <= MAX_LO) begin
            out_d = load_value;
          end else begin
            out_d      = MAX_LO;
            load_err_d = 1'b1;
          end
        end
        default: out_d = out_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q      <= RST_LO;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign out      = out_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  assign at_max   = (out_q == MAX_LO);
  assign at_zero  = (out_q == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param (MAX_VALUE=9): directed vector table followed by
// randomized stimulus checked against an arithmetic reference model.
module tb_updown_counter_param;

  localparam int W   = 16;
  localparam int SW  = 3;
  localparam int MAX = 9;
  localparam int RV  = 0;
`ifdef UPDOWN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [1:0]    control;
  logic [SW-1:0] step;
  logic [W-1:0]  load_value;
  logic [W-1:0]  out;
  logic          wrap, load_err, at_max, at_zero;

  updown_counter_param #(
    .WIDTH(W), .STEP_WIDTH(SW), .MAX_VALUE(MAX), .RESET_VALUE(RV)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .control(control),
    .step(step), .load_value(load_value), .out(out), .wrap(wrap),
    .load_err(load_err), .at_max(at_max), .at_zero(at_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit        rst;
    bit        en;
    bit [1:0]  ctrl;
    int        stp;
    int        lv;
    int        e_out;
    bit        e_wrap;
    bit        e_lerr;
  } vec_t;

  vec_t vq[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   m_out;

  task automatic add(input bit rst, input bit en, input bit [1:0] ctrl, input int stp,
                     input int lv, input int e_out, input bit e_wrap, input bit e_lerr);
    vec_t v;
    v = '{rst: rst, en: en, ctrl: ctrl, stp: stp, lv: lv,
          e_out: e_out, e_wrap: e_wrap, e_lerr: e_lerr};
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
      n_miss++;
    end
  endtask

  task automatic drive_cycle(input vec_t v);
    reset      = v.rst;
    enable     = v.en;
    control    = v.ctrl;
    step       = v.stp[SW-1:0];
    load_value = v.lv[W-1:0];
    @(posedge clock);
    #1;
  endtask

  task automatic compare(input string tag, input vec_t v);
    n_vec++;
    check({tag, " out"},      {16'b0, out},      v.e_out);
    check({tag, " wrap"},     {31'b0, wrap},     {31'b0, v.e_wrap});
    check({tag, " load_err"}, {31'b0, load_err}, {31'b0, v.e_lerr});
    check({tag, " at_max"},   {31'b0, at_max},   (v.e_out == MAX) ? 32'd1 : 32'd0);
    check({tag, " at_zero"},  {31'b0, at_zero},  (v.e_out == 0) ? 32'd1 : 32'd0);
  endtask

  // Reference: plain integer arithmetic on the counting rules.
  task automatic model(inout vec_t v);
    int s;
    v.e_wrap = 1'b0;
    v.e_lerr = 1'b0;
    if (v.rst) begin
      m_out = RV;
    end else if (v.en) begin
      case (v.ctrl)
        2'b00: m_out = 0;
        2'b01: begin
          s = m_out + v.stp;
          if (s > MAX) begin
            v.e_wrap = 1'b1;
            m_out = SAT ? MAX : s - (MAX + 1);
          end else m_out = s;
        end
        2'b11: begin
          s = m_out - v.stp;
          if (s < 0) begin
            v.e_wrap = 1'b1;
            m_out = SAT ? 0 : s + (MAX + 1);
          end else m_out = s;
        end
        default: begin
          if (v.lv > MAX) begin
            m_out = MAX;
            v.e_lerr = 1'b1;
          end else m_out = v.lv;
        end
      endcase
    end
    v.e_out = m_out;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; control = 2'b00; step = '0; load_value = '0;

    // reset, basic count
    add(1, 0, 2'b00, 0, 0,  RV, 0, 0);
    add(1, 0, 2'b00, 0, 0,  RV, 0, 0);
    for (int i = 1; i <= 5; i++) add(0, 1, 2'b01, 1, 0, i, 0, 0);
    // modulo wrap up
    add(0, 1, 2'b10, 0, 8,  8, 0, 0);
    add(0, 1, 2'b01, 3, 0,  SAT ? 9 : 1, 1, 0);
    add(0, 1, 2'b10, 0, 1,  1, 0, 0);
    add(0, 1, 2'b01, 7, 0,  8, 0, 0);
    add(0, 1, 2'b01, 1, 0,  9, 0, 0);
    // wrap down, step 0 holds
    add(0, 1, 2'b10, 0, 2,  2, 0, 0);
    add(0, 1, 2'b11, 5, 0,  SAT ? 0 : 7, 1, 0);
    add(0, 1, 2'b11, 0, 0,  SAT ? 0 : 7, 0, 0);
    add(0, 1, 2'b10, 0, 1,  1, 0, 0);
    add(0, 1, 2'b11, 4, 0,  SAT ? 0 : 7, 1, 0);
    // enable low holds, clear, reset beats load and wrap
    add(0, 1, 2'b10, 0, 5,  5, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 2'b00, 0, 0, 5, 0, 0);
    add(0, 1, 2'b00, 0, 0,  0, 0, 0);
    add(0, 1, 2'b10, 0, 6,  6, 0, 0);
    add(1, 1, 2'b10, 0, 3,  RV, 0, 0);
    add(0, 1, 2'b10, 0, 9,  9, 0, 0);
    add(1, 1, 2'b01, 3, 0,  RV, 0, 0);
    // out-of-range load
    add(0, 1, 2'b10, 0, 12, 9, 0, 1);
    add(0, 1, 2'b10, 0, 4,  4, 0, 0);
    add(0, 1, 2'b10, 0, 10, 9, 0, 1);
    add(0, 1, 2'b10, 0, 65535, 9, 0, 1);
    add(0, 0, 2'b10, 0, 12, 9, 0, 0);
    // back-to-back wraps, then hold cases
    add(0, 1, 2'b10, 0, 9,  9, 0, 0);
    add(0, 1, 2'b01, 5, 0,  SAT ? 9 : 4, 1, 0);
    add(0, 1, 2'b01, 7, 0,  SAT ? 9 : 1, 1, 0);
    add(0, 1, 2'b01, 0, 0,  SAT ? 9 : 1, 0, 0);
    add(0, 0, 2'b01, 7, 0,  SAT ? 9 : 1, 0, 0);
    // down to exactly zero, then underflow by one
    add(0, 1, 2'b10, 0, 3,  3, 0, 0);
    add(0, 1, 2'b11, 3, 0,  0, 0, 0);
    add(0, 1, 2'b11, 1, 0,  SAT ? 0 : 9, 1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive_cycle(vq[i]);
      compare($sformatf("vec%0d", i), vq[i]);
    end

    m_out = RV;
    for (int i = 0; i < 600; i++) begin
      vec_t v;
      v.rst  = (i == 0) || ($urandom_range(0, 49) == 0);
      v.en   = ($urandom_range(0, 7) != 0);
      v.ctrl = 2'($urandom_range(0, 3));
      v.stp  = $urandom_range(0, (1 << SW) - 1);
      v.lv   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 15);
      model(v);
      drive_cycle(v);
      compare($sformatf("rnd%0d", i), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
